// File: rtl/imm_ext_pkg.sv
// Shared definitions for the elastic immediate extender: extension mode codes
// and buffer occupancy states.
package imm_ext_pkg;

    localparam logic [1:0] EXT_ZERO   = 2'b00;
    localparam logic [1:0] EXT_SIGN   = 2'b01;
    localparam logic [1:0] EXT_UPPER  = 2'b10;
    localparam logic [1:0] EXT_BRANCH = 2'b11;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } state_t;

endpackage

// File: rtl/imm_ext_unit.sv
// Combinational immediate extender: zero, sign, upper-placement and
// sign-extended branch offset shifted left by SHAMT.
module imm_ext_unit
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int SHAMT = 2
) (
    input  logic [1:0]       ext_mode,
    input  logic [IN_W-1:0]  immediate,
    output logic [OUT_W-1:0] ext_value
);

    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] sext;

    // Shifting the all-ones mask by IN_W leaves exactly the bits above the immediate.
    assign zext = OUT_W'(immediate);
    assign sext = zext | ({OUT_W{immediate[IN_W-1]}} << IN_W);

    always_comb begin
        ext_value = zext;
        case (ext_mode)
            EXT_ZERO:   ext_value = zext;
            EXT_SIGN:   ext_value = sext;
            EXT_UPPER:  ext_value = zext << (OUT_W - IN_W);
            default:    ext_value = sext << SHAMT;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Elastic immediate extender with a registered 2-entry skid buffer.
// Define IMM_EXT_STATS_EN to add the saturating accepted-transaction counter stat_count.
//
// state | meaning
// EMPTY | no valid result, DataOut holds last value
// ONE   | DataOut valid, skid register unused
// FULL  | DataOut valid, skid register holds the next result, in_ready low
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int SHAMT = 2,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ExtMode,
    input  logic [IN_W-1:0]  immediate,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] DataOut,
    output logic             busy
`ifdef IMM_EXT_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_count
`endif
);

    if (OUT_W < IN_W || CNT_W < 1) begin : g_param_check
        $error("imm_extend_pipe: OUT_W must be >= IN_W and CNT_W >= 1");
    end

    state_t           state;
    logic [OUT_W-1:0] ext_value;
    logic [OUT_W-1:0] skid_q;
    logic             accept;
    logic             pop;

    imm_ext_unit #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SHAMT (SHAMT)
    ) u_ext (
        .ext_mode  (ExtMode),
        .immediate (immediate),
        .ext_value (ext_value)
    );

    // RST gates in_ready directly so nothing is accepted while reset is held.
    assign in_ready  = RST && (state != FULL);
    assign out_valid = (state != EMPTY);
    assign busy      = out_valid;
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= EMPTY;
            DataOut <= '0;
            skid_q  <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        DataOut <= ext_value;
                        state   <= ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        DataOut <= ext_value;
                    end else if (accept) begin
                        skid_q <= ext_value;
                        state  <= FULL;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        DataOut <= skid_q;
                        state   <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef IMM_EXT_STATS_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stat_count <= '0;
        end else if (accept && (stat_count != {CNT_W{1'b1}})) begin
            stat_count <= stat_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: mode table, back-pressure, streaming,
// asynchronous reset and (with IMM_EXT_STATS_EN) counter saturation.
module tb_imm_extend_pipe;

    logic        CLK;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  ExtMode;
    logic [15:0] immediate;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] DataOut;
    logic        busy;
`ifdef IMM_EXT_STATS_EN
    logic [3:0]  stat_count;
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    imm_extend_pipe #(
        .IN_W  (16),
        .OUT_W (32),
        .SHAMT (2),
        .CNT_W (4)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ExtMode   (ExtMode),
        .immediate (immediate),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .DataOut   (DataOut),
        .busy      (busy)
`ifdef IMM_EXT_STATS_EN
        ,
        .stat_count(stat_count)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        vecs[0] = '{2'b00, 16'h8001, 32'h00008001};
        vecs[1] = '{2'b01, 16'h8001, 32'hFFFF8001};
        vecs[2] = '{2'b10, 16'h8001, 32'h80010000};
        vecs[3] = '{2'b11, 16'h8001, 32'hFFFE0004};
        vecs[4] = '{2'b01, 16'h7FFF, 32'h00007FFF};
        vecs[5] = '{2'b11, 16'h7FFF, 32'h0001FFFC};
        vecs[6] = '{2'b00, 16'hFFFF, 32'h0000FFFF};
        vecs[7] = '{2'b10, 16'h1234, 32'h12340000};

        RST       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ExtMode   = 2'b00;
        immediate = 16'h0000;
        #12;
        chk("reset in_ready",  {31'd0, in_ready},  32'd0);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset busy",      {31'd0, busy},      32'd0);
        chk("reset DataOut",   DataOut,            32'd0);
`ifdef IMM_EXT_STATS_EN
        chk("reset stat_count", {28'd0, stat_count}, 32'd0);
`endif
        RST = 1'b1;
        #1;
        chk("release in_ready", {31'd0, in_ready}, 32'd1);

        // Mode table, one accept per cycle with the consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid  = 1'b1;
            ExtMode   = vecs[i].mode;
            immediate = vecs[i].imm;
            tick();
            chk($sformatf("mode vec%0d out_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("mode vec%0d DataOut", i), DataOut, vecs[i].exp);
        end
        in_valid = 1'b0;
        tick();
        chk("drain out_valid", {31'd0, out_valid}, 32'd0);
        chk("drain DataOut keeps last", DataOut, 32'h12340000);

        // Back-pressure fills the skid buffer
        out_ready = 1'b0;
        in_valid  = 1'b1;
        ExtMode   = 2'b01;
        immediate = 16'h0001;
        tick();
        chk("bp first in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp first DataOut", DataOut, 32'h00000001);
        immediate = 16'h0002;
        tick();
        chk("bp full in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp full DataOut", DataOut, 32'h00000001);
        immediate = 16'h0003;
        tick();
        chk("bp held in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp held DataOut", DataOut, 32'h00000001);
        chk("bp held out_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;

        // Drain from FULL
        out_ready = 1'b1;
        #1;
        chk("pop0 DataOut", DataOut, 32'h00000001);
        tick();
        chk("pop1 DataOut", DataOut, 32'h00000002);
        chk("pop1 out_valid", {31'd0, out_valid}, 32'd1);
        chk("pop1 in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("pop2 out_valid", {31'd0, out_valid}, 32'd0);
        chk("pop2 busy", {31'd0, busy}, 32'd0);
        tick();
        chk("pop3 out_valid", {31'd0, out_valid}, 32'd0);

        // Single-cycle throughput stream
        in_valid = 1'b1;
        ExtMode  = 2'b00;
        immediate = 16'h00FF;
        tick();
        for (int i = 0; i < 8; i++) begin
            immediate = 16'h0100 + 16'(i);
            tick();
            chk($sformatf("stream%0d DataOut", i), DataOut, 32'h00000100 + 32'(i));
            chk($sformatf("stream%0d busy", i), {31'd0, busy}, 32'd1);
            chk($sformatf("stream%0d in_ready", i), {31'd0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream end out_valid", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset while FULL
        out_ready = 1'b0;
        in_valid  = 1'b1;
        ExtMode   = 2'b01;
        immediate = 16'hAAAA;
        tick();
        immediate = 16'hBBBB;
        tick();
        in_valid = 1'b0;
        chk("pre-reset in_ready", {31'd0, in_ready}, 32'd0);
        #2;
        RST = 1'b0;
        #1;
        chk("async rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("async rst in_ready", {31'd0, in_ready}, 32'd0);
        chk("async rst DataOut", DataOut, 32'd0);
        tick();
        #2;
        RST = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("post-rst%0d out_valid", i), {31'd0, out_valid}, 32'd0);
        end
        in_valid  = 1'b1;
        ExtMode   = 2'b00;
        immediate = 16'h0005;
        tick();
        in_valid = 1'b0;
        chk("post-rst accept DataOut", DataOut, 32'h00000005);
        tick();
        chk("post-rst accept drained", {31'd0, out_valid}, 32'd0);

`ifdef IMM_EXT_STATS_EN
        RST = 1'b0;
        #3;
        RST = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            immediate = 16'(i);
            tick();
            if (i == 13) chk("stat after 14", {28'd0, stat_count}, 32'hE);
        end
        in_valid = 1'b0;
        tick();
        chk("stat saturated", {28'd0, stat_count}, 32'hF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
